maple_receiver: RTL and testbench

Receive-side Maple Bus decoder: samples the two bidirectional clock/data lines SDCKA/SDCKB while the bus is released and recognises the start pattern. It decodes MSB-first data bits, recognises the end pattern, and delivers each byte on an AXI4-Stream master with TLAST on the final byte of the frame. It sits alongside the transmitter on the same bus pins; the bus arbiter enables it whenever the transmitter is idle.

---
 rtl/maple_receiver_if.sv | 23 ++
 rtl/maple_receiver.sv | 210 +++++++++++++++++++++
 tb/tb_maple_receiver.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maple_receiver_if.sv
// AXI4-Stream byte channel from the Maple Bus receiver to its sink.
interface maple_receiver_if #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 8
);
  logic                            M_AXIS_TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                            M_AXIS_TLAST;
  logic                            M_AXIS_TREADY;

  modport master (
    output M_AXIS_TVALID,
    output M_AXIS_TDATA,
    output M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TVALID,
    input  M_AXIS_TDATA,
    input  M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/maple_receiver.sv
// Maple Bus receive decoder: detects start/end patterns on SDCKA/SDCKB, decodes MSB-first
// bits and streams bytes out with one byte of latency so TLAST marks the true final byte.
module maple_receiver #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES       = 4096
) (
  input  logic             M_AXIS_ACLK,
  input  logic             M_AXIS_ARESET,
  input  logic             SDCKA,
  input  logic             SDCKB,
  input  logic             ENABLE,
  maple_receiver_if.master m_axis,
  output logic             RECEIVING,
  output logic             FRAME_ERROR,
  output logic             OVERFLOW
);
  localparam int unsigned     DW       = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StStart, StDataA, StDataB, StEnd} state_e;

  logic [1:0] sync_a_q, sync_b_q;
  logic       prev_a_q, prev_b_q;
  logic       a_s, b_s, a_fall, a_rise, b_fall, b_rise, any_edge;

  state_e          state_q;
  logic [2:0]      pulse_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [DW-2:0]   shift_q;
  logic [DW-1:0]   hold_q;
  logic            hold_valid_q;
  logic [TmoW-1:0] tmo_q;
  logic            receiving_q;
  logic            frame_error_q;

  logic          tvalid_q, tlast_q, overflow_q;
  logic [DW-1:0] tdata_q;

  logic          tmo_hit, shift_en, shift_bit, byte_done, frame_done, push;
  logic [2:0]    bit_cnt_next;
  logic [DW-1:0] byte_next;

  // Two-flop synchronisers plus previous-value registers; idle bus level is high.
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      sync_a_q <= 2'b11;
      sync_b_q <= 2'b11;
      prev_a_q <= 1'b1;
      prev_b_q <= 1'b1;
    end else begin
      sync_a_q <= {sync_a_q[0], SDCKA};
      sync_b_q <= {sync_b_q[0], SDCKB};
      prev_a_q <= sync_a_q[1];
      prev_b_q <= sync_b_q[1];
    end
  end

  assign a_s      = sync_a_q[1];
  assign b_s      = sync_b_q[1];
  assign a_fall   = prev_a_q & ~a_s;
  assign a_rise   = ~prev_a_q & a_s;
  assign b_fall   = prev_b_q & ~b_s;
  assign b_rise   = ~prev_b_q & b_s;
  assign any_edge = a_fall | a_rise | b_fall | b_rise;

  // Data-bit capture, byte completion and frame completion events.
  always_comb begin
    tmo_hit   = (state_q != StIdle) && (tmo_q == TmoLimit);
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    if (!tmo_hit) begin
      if (state_q == StDataA && a_fall) begin
        shift_en  = 1'b1;
        shift_bit = b_s;
      end else if (state_q == StDataB && b_fall) begin
        // SDCKB fall wins over a simultaneous SDCKA fall in this phase
        shift_en  = 1'b1;
        shift_bit = a_s;
      end
    end
    byte_next    = {shift_q, shift_bit};
    bit_cnt_next = bit_cnt_q + 3'd1;
    byte_done    = shift_en && (bit_cnt_next == 3'd0);
    frame_done   = !tmo_hit && (state_q == StEnd) && b_rise && a_s;
    push         = (byte_done || frame_done) && hold_valid_q;
  end

  // Frame FSM with hold byte, timeout counter and registered status outputs.
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q       <= StIdle;
      pulse_cnt_q   <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      tmo_q         <= '0;
      receiving_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      if (state_q == StIdle || any_edge) tmo_q <= '0;
      else                               tmo_q <= tmo_q + TmoW'(1);
      if (shift_en) begin
        shift_q   <= byte_next[DW-2:0];
        bit_cnt_q <= bit_cnt_next;
      end
      if (byte_done) begin
        hold_q       <= byte_next;
        hold_valid_q <= 1'b1;
      end
      if (tmo_hit) begin
        state_q       <= StIdle;
        receiving_q   <= 1'b0;
        frame_error_q <= 1'b1;
        hold_valid_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (a_fall && b_s && ENABLE) begin
              state_q     <= StStart;
              pulse_cnt_q <= '0;
              receiving_q <= 1'b1;
            end
          end
          StStart: begin
            if (a_rise) begin
              if (pulse_cnt_q == 3'd4) begin
                state_q   <= StDataA;
                bit_cnt_q <= '0;
              end else begin
                state_q       <= StIdle;
                receiving_q   <= 1'b0;
                frame_error_q <= 1'b1;
              end
            end else if (b_fall && !a_s && pulse_cnt_q != 3'd7) begin
              pulse_cnt_q <= pulse_cnt_q + 3'd1;
            end
          end
          StDataA: begin
            if (a_fall) state_q <= StDataB;
          end
          StDataB: begin
            if (b_fall) begin
              state_q <= StDataA;
            end else if (a_fall) begin
              // Second SDCKA pulse after a tentative 0 with SDCKB low is the end pattern
              if (bit_cnt_q == 3'd1 && !shift_q[0] && !b_s) begin
                state_q <= StEnd;
              end else begin
                state_q       <= StIdle;
                receiving_q   <= 1'b0;
                frame_error_q <= 1'b1;
                hold_valid_q  <= 1'b0;
              end
            end
          end
          StEnd: begin
            if (frame_done) begin
              state_q      <= StIdle;
              receiving_q  <= 1'b0;
              hold_valid_q <= 1'b0;
            end else if (a_fall) begin
              state_q       <= StIdle;
              receiving_q   <= 1'b0;
              frame_error_q <= 1'b1;
              hold_valid_q  <= 1'b0;
            end
          end
          default: begin
            state_q     <= StIdle;
            receiving_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Single-entry output register; a push into a stalled register is dropped.
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (push) begin
        if (!tvalid_q || m_axis.M_AXIS_TREADY) begin
          tvalid_q <= 1'b1;
          tdata_q  <= hold_q;
          tlast_q  <= frame_done;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis.M_AXIS_TREADY) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.M_AXIS_TVALID = tvalid_q;
  assign m_axis.M_AXIS_TDATA  = tdata_q;
  assign m_axis.M_AXIS_TLAST  = tlast_q;
  assign RECEIVING            = receiving_q;
  assign FRAME_ERROR          = frame_error_q;
  assign OVERFLOW             = overflow_q;

endmodule

// File: tb/tb_maple_receiver.sv
// Bench for maple_receiver: drives Maple Bus waveforms, predicts beats from frame contents
// and checks them in a decoupled monitor.
module tb_maple_receiver;
  localparam int STEP = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk, rst, SDCKA, SDCKB, ENABLE;
  logic RECEIVING, FRAME_ERROR, OVERFLOW;
  logic rand_ready, ready_force;

  maple_receiver_if #(.C_M_AXIS_TDATA_WIDTH(8)) axis ();

  maple_receiver #(
    .C_M_AXIS_TDATA_WIDTH(8),
    .TIMEOUT_CYCLES      (4096)
  ) dut (
    .M_AXIS_ACLK  (clk),
    .M_AXIS_ARESET(rst),
    .SDCKA        (SDCKA),
    .SDCKB        (SDCKB),
    .ENABLE       (ENABLE),
    .m_axis       (axis),
    .RECEIVING    (RECEIVING),
    .FRAME_ERROR  (FRAME_ERROR),
    .OVERFLOW     (OVERFLOW)
  );

  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int exp_err = 0;
  int exp_ovf = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  // Sink readiness: random per cycle, or a forced level.
  initial begin
    axis.M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) axis.M_AXIS_TREADY = 1'($urandom_range(0, 1));
      else            axis.M_AXIS_TREADY = ready_force;
    end
  end

  // Monitor: counts status pulses and pops the scoreboard on each accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (FRAME_ERROR) err_cnt++;
      if (OVERFLOW) ovf_cnt++;
      if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                   axis.M_AXIS_TDATA, axis.M_AXIS_TLAST);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", 32'(axis.M_AXIS_TDATA), 32'(e.data));
          check("beat_last", 32'(axis.M_AXIS_TLAST), 32'(e.last));
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    miscompares++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic set_lines(input logic a, input logic b);
    #2;
    SDCKA = a;
    SDCKB = b;
    repeat (STEP) @(posedge clk);
  endtask

  task automatic send_start(input int n);
    set_lines(1'b1, 1'b1);
    set_lines(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      set_lines(1'b0, 1'b0);
      set_lines(1'b0, 1'b1);
    end
    set_lines(1'b1, 1'b1);
  endtask

  // Bit carried on SDCKB, latched by an SDCKA fall.
  task automatic phase_a(input logic v);
    if (!SDCKA) set_lines(1'b1, SDCKB);
    set_lines(1'b1, v);
    set_lines(1'b0, v);
  endtask

  // Bit carried on SDCKA, latched by an SDCKB fall.
  task automatic phase_b(input logic v);
    if (!SDCKB) set_lines(SDCKA, 1'b1);
    set_lines(v, 1'b1);
    set_lines(v, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i > 0; i -= 2) begin
      phase_a(v[i]);
      phase_b(v[i-1]);
    end
  endtask

  task automatic send_end();
    if (!SDCKA) set_lines(1'b1, SDCKB);
    set_lines(1'b1, 1'b0);
    set_lines(1'b0, 1'b0);
    set_lines(1'b1, 1'b0);
    set_lines(1'b0, 1'b0);
    set_lines(1'b1, 1'b0);
    set_lines(1'b1, 1'b1);
  endtask

  task automatic finish_frame(input string name);
    int n;
    set_lines(1'b1, 1'b1);
    set_lines(1'b1, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_pending_beats"}, 32'(sb.size()), 32'd0);
    check({name, "_frame_errors"}, 32'(err_cnt), 32'(exp_err));
    check({name, "_overflows"}, 32'(ovf_cnt), 32'(exp_ovf));
    check({name, "_receiving"}, 32'(RECEIVING), 32'd0);
  endtask

  initial begin
    logic [7:0] bytes [4];
    int mode, nb, cnt, n;

    rst = 1'b1;
    SDCKA = 1'b1;
    SDCKB = 1'b1;
    ENABLE = 1'b1;
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(axis.M_AXIS_TVALID), 32'd0);
    check("rst_tdata", 32'(axis.M_AXIS_TDATA), 32'd0);
    check("rst_tlast", 32'(axis.M_AXIS_TLAST), 32'd0);
    check("rst_receiving", 32'(RECEIVING), 32'd0);
    check("rst_frame_error", 32'(FRAME_ERROR), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Two-byte frame, sink always ready
    push_beat(8'hA5, 1'b0);
    push_beat(8'h3C, 1'b1);
    send_start(4);
    @(negedge clk);
    check("t1_receiving_mid", 32'(RECEIVING), 32'd1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_end();
    finish_frame("t1");

    // Start with only three SDCKB pulses
    send_start(3);
    exp_err++;
    finish_frame("t2");

    // Bus goes quiet after one byte: timeout abort, held byte discarded
    send_start(4);
    send_byte(8'hFF);
    n = 0;
    while (err_cnt == exp_err && n < 4400) begin
      @(posedge clk);
      n++;
    end
    exp_err++;
    @(negedge clk);
    check("t3_timeout_error", 32'(err_cnt), 32'(exp_err));
    check("t3_timeout_window", 32'(n >= 4088 && n <= 4098), 32'd1);
    check("t3_receiving", 32'(RECEIVING), 32'd0);
    finish_frame("t3");

    // Backpressure: first byte held, second and third dropped
    ready_force = 1'b0;
    send_start(4);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_end();
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_ovf += 2;
    check("t4_overflows", 32'(ovf_cnt), 32'(exp_ovf));
    check("t4_tvalid", 32'(axis.M_AXIS_TVALID), 32'd1);
    check("t4_tdata", 32'(axis.M_AXIS_TDATA), 32'h01);
    check("t4_tlast", 32'(axis.M_AXIS_TLAST), 32'd0);
    push_beat(8'h01, 1'b0);
    ready_force = 1'b1;
    finish_frame("t4");

    // Zero-byte frame
    send_start(4);
    send_end();
    finish_frame("t5");

    // Frame while disabled is ignored
    ENABLE = 1'b0;
    send_start(4);
    @(negedge clk);
    check("t6_receiving_disabled", 32'(RECEIVING), 32'd0);
    send_byte(8'h77);
    send_end();
    finish_frame("t6");
    ENABLE = 1'b1;

    // Reset in the middle of a byte with a beat stalled in the output register
    ready_force = 1'b0;
    send_start(4);
    send_byte(8'h11);
    send_byte(8'h22);
    phase_a(1'b1);
    phase_b(1'b0);
    phase_a(1'b1);
    phase_b(1'b0);
    @(negedge clk);
    check("t7_stalled_tvalid", 32'(axis.M_AXIS_TVALID), 32'd1);
    check("t7_stalled_tdata", 32'(axis.M_AXIS_TDATA), 32'h11);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_tvalid", 32'(axis.M_AXIS_TVALID), 32'd0);
    check("t7_rst_tdata", 32'(axis.M_AXIS_TDATA), 32'd0);
    check("t7_rst_tlast", 32'(axis.M_AXIS_TLAST), 32'd0);
    check("t7_rst_receiving", 32'(RECEIVING), 32'd0);
    check("t7_rst_frame_error", 32'(FRAME_ERROR), 32'd0);
    check("t7_rst_overflow", 32'(OVERFLOW), 32'd0);
    SDCKA = 1'b1;
    SDCKB = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    ready_force = 1'b1;
    repeat (4) @(posedge clk);
    push_beat(8'h5A, 1'b1);
    send_start(4);
    send_byte(8'h5A);
    send_end();
    finish_frame("t7");

    // Random frames: good, bad start count, or aborted after some bytes
    rand_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      mode = $urandom_range(0, 2);
      nb = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
      if (mode == 1) begin
        cnt = $urandom_range(0, 8);
        if (cnt >= 4) cnt++;
        send_start(cnt);
        exp_err++;
      end else begin
        for (int i = 0; i < nb; i++) begin
          if (mode == 0) push_beat(bytes[i], 1'(i == nb - 1));
          else if (i < nb - 1) push_beat(bytes[i], 1'b0);
        end
        send_start(4);
        for (int i = 0; i < nb; i++) send_byte(bytes[i]);
        if (mode == 0) begin
          send_end();
        end else begin
          // A tentative 1 followed by another SDCKA pulse is not a valid end pattern
          phase_a(1'b1);
          set_lines(1'b1, 1'b1);
          set_lines(1'b0, 1'b1);
          exp_err++;
        end
      end
      finish_frame("rand");
    end
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
